// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the RV32I 5-stage pipeline.
// Arbitrates memory freeze, taken-branch squash and load-use stall into per-register
// stall/flush controls. A small FSM tracks outstanding data-memory waits and raises a
// sticky fault on timeout. Saturating counters record stall cycles and branch redirects.
module pipeline_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,  // legal range 2..255
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             fault_clr,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             pc_sel_branch,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

   // Last wait-counter value tolerated before the access is declared lost.
   localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic freeze;
   logic load_use;
   logic branch_go;
   logic lu_go;

   // FSM next state, wait counter and sticky fault flag.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      fault_d    = fault_q;
      case (state_q)
         StRun: begin
            // req with same-cycle ack is a zero-wait access: stay in RUN.
            if (dmem_req && !dmem_ack) begin
               state_d = StMemWait;
            end
         end
         StMemWait: begin
            if (dmem_ack) begin
               state_d = StRun;
            end else if (wait_cnt_q == WaitLast) begin
               state_d = StFault;
               fault_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StFault: begin
            if (fault_clr) begin
               state_d = StRun;
               fault_d = 1'b0;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Hazard arbitration: freeze > taken branch > load-use.
   always_comb begin
      freeze = ((state_q == StRun) && dmem_req && !dmem_ack) ||
               ((state_q == StMemWait) && !dmem_ack) ||
               (state_q == StFault);
      load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      branch_go = !freeze && ex_valid && branch_taken;
      lu_go     = !freeze && !branch_go && load_use;
   end

   // Pipeline-register controls; forced low while reset is held.
   always_comb begin
      pc_stall      = rst_n && (freeze || lu_go);
      if_id_stall   = rst_n && (freeze || lu_go);
      if_id_flush   = rst_n && branch_go;
      id_ex_stall   = rst_n && freeze;
      id_ex_flush   = rst_n && (branch_go || lu_go);
      ex_mem_stall  = rst_n && freeze;
      pc_sel_branch = rst_n && branch_go;
   end

   // Saturating performance counter next values.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (pc_sel_branch && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State, wait counter, fault flag and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         fault_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         fault_q     <= fault_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_fault    = fault_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule
